// File: rtl/ffight_adc_pkg.sv
// rtl/ffight_adc_pkg.sv - shared types and constants for the Food Fight ADC0809 emulation
// The optional background scanner is enabled with ADC_SCAN_EN.
package ffight_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } adc_state_t;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned NUM_ANA = 4;
  localparam int unsigned CH_W    = 3;

  localparam int unsigned DEF_CONV_CYCLES = 8;
  localparam logic [7:0]  DEF_FILL_VAL    = 8'hFF;

  // Only channels 0..3 are wired to sticks; the rest read back a fixed fill value.
  function automatic logic [7:0] ain_mux(input logic [CH_W-1:0] ch,
                                         input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3,
                                         input logic [7:0] fill);
    case (ch)
      3'd0:    return a0;
      3'd1:    return a1;
      3'd2:    return a2;
      3'd3:    return a3;
      default: return fill;
    endcase
  endfunction

endpackage

// File: rtl/ffight_adc_scan.sv
// rtl/ffight_adc_scan.sv - round-robin shadow sampler for the four stick channels
// Instantiated by ffight_adc_sched only when ADC_SCAN_EN is defined.
module ffight_adc_scan
  import ffight_adc_pkg::*;
#(
  parameter logic [7:0] FILL_VAL = DEF_FILL_VAL
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic            en_i,
  input  logic [7:0]      ain0_i,
  input  logic [7:0]      ain1_i,
  input  logic [7:0]      ain2_i,
  input  logic [7:0]      ain3_i,
  input  logic [CH_W-1:0] sel_i,
  output logic [7:0]      data_o
);

  logic [7:0] shadow_q [NUM_ANA];
  logic [1:0] ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ANA; i++) shadow_q[i] <= 8'h00;
      ptr_q <= 2'd0;
    end else if (ce_i && en_i) begin
      shadow_q[ptr_q] <= ain_mux({1'b0, ptr_q}, ain0_i, ain1_i, ain2_i, ain3_i, FILL_VAL);
      ptr_q           <= ptr_q + 2'd1;
    end
  end

  assign data_o = sel_i[2] ? FILL_VAL : shadow_q[sel_i[1:0]];

endmodule

// File: rtl/ffight_adc_sched.sv
// rtl/ffight_adc_sched.sv - ADC0809-style conversion sequencer shared by the four stick axes
// Define ADC_SCAN_EN to add SCAN_MODE and the shadow-register fast path.
module ffight_adc_sched
  import ffight_adc_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = DEF_CONV_CYCLES,
  parameter logic [7:0]  FILL_VAL    = DEF_FILL_VAL
) (
  input  logic            MCLK,
  input  logic            RESET_N,
  input  logic            CE,
  input  logic            START,
  input  logic [CH_W-1:0] CH,
  input  logic [7:0]      AIN0,
  input  logic [7:0]      AIN1,
  input  logic [7:0]      AIN2,
  input  logic [7:0]      AIN3,
`ifdef ADC_SCAN_EN
  input  logic            SCAN_MODE,
`endif
  output logic [7:0]      DOUT,
  output logic            EOC,
  output logic            BUSY
);

  localparam logic [7:0] CONV_M1 = 8'(CONV_CYCLES - 1);

  if (CONV_CYCLES < 1 || CONV_CYCLES > 255) begin : g_bad_conv_cycles
    $error("CONV_CYCLES must be in 1..255");
  end

  adc_state_t      state_q;
  logic [CH_W-1:0] chan_q;
  logic [7:0]      cnt_q;
  logic [7:0]      sample_q;
  logic [7:0]      dout_q;
  logic            eoc_q;
  logic            busy_q;
  logic [7:0]      ain_sel;

  assign ain_sel = ain_mux(chan_q, AIN0, AIN1, AIN2, AIN3, FILL_VAL);

`ifdef ADC_SCAN_EN
  logic [7:0] shadow_sel;

  ffight_adc_scan #(.FILL_VAL(FILL_VAL)) u_scan (
    .clk_i  (MCLK),
    .rst_ni (RESET_N),
    .ce_i   (CE),
    .en_i   (SCAN_MODE),
    .ain0_i (AIN0),
    .ain1_i (AIN1),
    .ain2_i (AIN2),
    .ain3_i (AIN3),
    .sel_i  (chan_q),
    .data_o (shadow_sel)
  );
`endif

  // START outranks CE so a CPU write always aborts and restarts the conversion.
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      cnt_q    <= 8'h00;
      sample_q <= 8'h00;
      dout_q   <= 8'h00;
      eoc_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else if (START) begin
      chan_q  <= CH;
      state_q <= SAMPLE;
      eoc_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else if (CE) begin
      case (state_q)
        SAMPLE: begin
`ifdef ADC_SCAN_EN
          if (SCAN_MODE) begin
            dout_q  <= shadow_sel;
            eoc_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else
`endif
          begin
            sample_q <= ain_sel;
            cnt_q    <= CONV_M1;
            state_q  <= CONVERT;
          end
        end
        CONVERT: begin
          if (cnt_q != 8'h00) begin
            cnt_q <= cnt_q - 8'h01;
          end else begin
            dout_q  <= sample_q;
            eoc_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign DOUT = dout_q;
  assign EOC  = eoc_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_ffight_adc_sched.sv
// tb/tb_ffight_adc_sched.sv - self-checking bench for ffight_adc_sched against a tick-counting model
module tb_ffight_adc_sched;

  localparam int         CONV = 8;
  localparam logic [7:0] FILL = 8'hFF;

  logic       MCLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CE = 1'b1;
  logic       START = 1'b0;
  logic [2:0] CH = 3'd0;
  logic [7:0] AIN0 = 8'h00, AIN1 = 8'h00, AIN2 = 8'h00, AIN3 = 8'h00;
  logic       SCAN_MODE = 1'b0;
  wire  [7:0] DOUT;
  wire        EOC;
  wire        BUSY;

  int n_chk  = 0;
  int n_fail = 0;
  int ce_mode = 0;
  int ce_cnt  = 0;

  ffight_adc_sched #(.CONV_CYCLES(CONV), .FILL_VAL(FILL)) dut (
    .MCLK      (MCLK),
    .RESET_N   (RESET_N),
    .CE        (CE),
    .START     (START),
    .CH        (CH),
    .AIN0      (AIN0),
    .AIN1      (AIN1),
    .AIN2      (AIN2),
    .AIN3      (AIN3),
`ifdef ADC_SCAN_EN
    .SCAN_MODE (SCAN_MODE),
`endif
    .DOUT      (DOUT),
    .EOC       (EOC),
    .BUSY      (BUSY)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request is pending from START until CONV+1 CE ticks have elapsed;
  // the value is picked on the first tick, published on the last.
  logic [7:0] m_dout = 8'h00;
  logic       m_pend = 1'b0;
  int         m_ticks = 0;
  logic [2:0] m_ch = 3'd0;
  logic [7:0] m_sample = 8'h00;
  logic [7:0] m_shadow [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int         m_ptr = 0;

  function automatic logic [7:0] m_src(input logic [2:0] c);
    case (c)
      3'd0:    return AIN0;
      3'd1:    return AIN1;
      3'd2:    return AIN2;
      3'd3:    return AIN3;
      default: return FILL;
    endcase
  endfunction

  always @(posedge MCLK) begin
    if (!RESET_N) begin
      m_dout = 8'h00; m_pend = 1'b0; m_ticks = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
    end else begin
      if (START) begin
        m_pend = 1'b1; m_ch = CH; m_ticks = 0;
      end else if (CE && m_pend) begin
        m_ticks++;
        if (m_ticks == 1 && SCAN_MODE) begin
          m_dout = (m_ch < 3'd4) ? m_shadow[m_ch[1:0]] : FILL;
          m_pend = 1'b0;
        end else if (m_ticks == 1) begin
          m_sample = m_src(m_ch);
        end else if (m_ticks == CONV + 1) begin
          m_dout = m_sample;
          m_pend = 1'b0;
        end
      end
      if (CE && SCAN_MODE) begin
        m_shadow[m_ptr] = m_src(3'(m_ptr));
        m_ptr = (m_ptr + 1) % 4;
      end
    end
  end

  always @(negedge MCLK) begin
    check("model_dout", DOUT, m_dout);
    check("model_eoc", EOC, !m_pend);
    check("model_busy", BUSY, m_pend);
  end

  initial begin
    forever begin
      @(negedge MCLK);
      ce_cnt++;
      case (ce_mode)
        0:       CE = 1'b1;
        1:       CE = (ce_cnt % 4 == 0);
        default: CE = ($urandom_range(0, 9) < 6);
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic pulse_start(input logic [2:0] c);
    CH = c; START = 1'b1;
    @(negedge MCLK);
    START = 1'b0;
  endtask

  task automatic wait_eoc(input int maxc, input string nm);
    int k = 0;
    while (!EOC && k < maxc) begin
      @(negedge MCLK);
      k++;
    end
    check(nm, EOC, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic saw33;
    logic early;
    RESET_N = 1'b0;
    cyc(2);
    RESET_N = 1'b1;
    #1;
    check("reset_dout", DOUT, 8'h00);
    check("reset_eoc", EOC, 1);
    check("reset_busy", BUSY, 0);

    AIN1 = 8'h5A;
    pulse_start(3'd1);
    #1;
    check("basic_eoc_low", EOC, 0);
    check("basic_busy", BUSY, 1);
    cyc(8);
    #1;
    check("basic_eoc_edge8", EOC, 0);
    cyc(1);
    #1;
    check("basic_dout", DOUT, 8'h5A);
    check("basic_eoc_edge9", EOC, 1);

    AIN2 = 8'h10;
    pulse_start(3'd2);
    cyc(1);
    AIN2 = 8'hEE;
    wait_eoc(20, "hold_eoc");
    #1;
    check("hold_dout", DOUT, 8'h10);

    AIN0 = 8'h33;
    AIN3 = 8'hC4;
    pulse_start(3'd0);
    cyc(4);
    pulse_start(3'd3);
    saw33 = 1'b0;
    early = 1'b0;
    for (int i = 6; i <= 13; i++) begin
      @(negedge MCLK);
      if (EOC) early = 1'b1;
      if (DOUT == 8'h33) saw33 = 1'b1;
    end
    @(negedge MCLK);
    #1;
    check("restart_dout", DOUT, 8'hC4);
    check("restart_eoc", EOC, 1);
    check("restart_no_33", saw33, 0);
    check("restart_no_early_eoc", early, 0);

    ce_mode = 1;
    pulse_start(3'd6);
    wait_eoc(60, "fill_eoc");
    #1;
    check("fill_dout", DOUT, 8'hFF);
    AIN1 = 8'h77;
    pulse_start(3'd1);
    cyc(20);
    #1;
    check("midconv_busy", BUSY, 1);
    RESET_N = 1'b0;
    cyc(1);
    RESET_N = 1'b1;
    #1;
    check("midreset_dout", DOUT, 8'h00);
    check("midreset_eoc", EOC, 1);
    check("midreset_busy", BUSY, 0);
    ce_mode = 0;

`ifdef ADC_SCAN_EN
    SCAN_MODE = 1'b1;
    AIN0 = 8'h11; AIN1 = 8'h22; AIN2 = 8'h33; AIN3 = 8'h44;
    cyc(8);
    pulse_start(3'd2);
    cyc(1);
    #1;
    check("scan_dout", DOUT, 8'h33);
    check("scan_eoc", EOC, 1);
    SCAN_MODE = 1'b0;
`endif

    ce_mode = 2;
    for (int i = 0; i < 600; i++) begin
      @(negedge MCLK);
      RESET_N = ($urandom_range(0, 199) != 0);
      START   = ($urandom_range(0, 24) == 0);
      CH      = 3'($urandom);
      AIN0    = 8'($urandom);
      AIN1    = 8'($urandom);
      AIN2    = 8'($urandom);
      AIN3    = 8'($urandom);
`ifdef ADC_SCAN_EN
      if (i % 50 == 0) SCAN_MODE = 1'($urandom);
`endif
    end
    @(negedge MCLK);
    START = 1'b0;
    RESET_N = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
